// File: rtl/fiber_cache_bank_if.sv
// rtl/fiber_cache_bank_if.sv - request/response and DRAM channel bundle for one fiber cache bank
// Ports (as seen by the bank through the slave modport):
//   request   : i_req_type/i_req_addr/i_req_data/i_req_valid in, o_req_ready out
//   response  : o_resp_data/o_resp_hit/o_resp_err/o_resp_valid out, i_resp_ready in
//   dram read : o_dram_rd_addr/o_dram_rd_valid out, i_dram_rd_ready in,
//               i_dram_rd_data/i_dram_rd_data_valid in, o_dram_rd_data_ready out
//   dram write: o_dram_wr_addr/o_dram_wr_data/o_dram_wr_valid out, i_dram_wr_ready in
interface fiber_cache_bank_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            i_req_type;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_data;
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [DATA_WIDTH-1:0] o_resp_data;
  logic                  o_resp_hit;
  logic                  o_resp_err;
  logic                  o_resp_valid;
  logic                  i_resp_ready;
  logic [ADDR_WIDTH-1:0] o_dram_rd_addr;
  logic                  o_dram_rd_valid;
  logic                  i_dram_rd_ready;
  logic [DATA_WIDTH-1:0] i_dram_rd_data;
  logic                  i_dram_rd_data_valid;
  logic                  o_dram_rd_data_ready;
  logic [ADDR_WIDTH-1:0] o_dram_wr_addr;
  logic [DATA_WIDTH-1:0] o_dram_wr_data;
  logic                  o_dram_wr_valid;
  logic                  i_dram_wr_ready;

  modport slave (
    input  i_req_type, i_req_addr, i_req_data, i_req_valid, i_resp_ready,
    input  i_dram_rd_ready, i_dram_rd_data, i_dram_rd_data_valid, i_dram_wr_ready,
    output o_req_ready, o_resp_data, o_resp_hit, o_resp_err, o_resp_valid,
    output o_dram_rd_addr, o_dram_rd_valid, o_dram_rd_data_ready,
    output o_dram_wr_addr, o_dram_wr_data, o_dram_wr_valid
  );

  modport master (
    output i_req_type, i_req_addr, i_req_data, i_req_valid, i_resp_ready,
    output i_dram_rd_ready, i_dram_rd_data, i_dram_rd_data_valid, i_dram_wr_ready,
    input  o_req_ready, o_resp_data, o_resp_hit, o_resp_err, o_resp_valid,
    input  o_dram_rd_addr, o_dram_rd_valid, o_dram_rd_data_ready,
    input  o_dram_wr_addr, o_dram_wr_data, o_dram_wr_valid
  );
endinterface

// File: rtl/fiber_cache_bank.sv
// rtl/fiber_cache_bank.sv - set-associative fiber cache bank, priority-then-SRRIP replacement
// Ports:
//   i_clk    : clock
//   i_nreset : synchronous active-low reset
//   bus      : fiber_cache_bank_if slave (PE request/response, DRAM read and write channels)
module fiber_cache_bank #(
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_BITS   = 3,
  parameter int SETS          = 16,
  parameter int WAYS          = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int SRRIP_BITS    = 2,
  parameter int PRIORITY_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_nreset,
  fiber_cache_bank_if.slave   bus
);
  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int TAG_BITS = ADDR_WIDTH - OFFSET_BITS - SET_BITS;
  // Newly allocated lines start one step short of "distant re-reference".
  localparam logic [SRRIP_BITS-1:0] SRRIP_INS = {{(SRRIP_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_DATA, RESP} state_t;
  state_t state_q, state_d;

  logic [3:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WAY_BITS-1:0]   vic_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_hit_q, resp_err_q;

  logic [TAG_BITS-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]    data_q  [SETS][WAYS];
  logic                     valid_q [SETS][WAYS];
  logic                     dirty_q [SETS][WAYS];
  logic [SRRIP_BITS-1:0]    srrip_q [SETS][WAYS];
  logic [PRIORITY_BITS-1:0] prio_q  [SETS][WAYS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] tag;
  logic is_fetch, is_read, is_write, is_consume;
  logic unused_offset;

  assign set_idx    = addr_q[OFFSET_BITS +: SET_BITS];
  assign tag        = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign is_fetch   = type_q[0];
  assign is_read    = type_q[1];
  assign is_write   = type_q[2];
  assign is_consume = type_q[3];
  assign unused_offset = ^addr_q[OFFSET_BITS-1:0];

  // Lookup and victim choice: invalid way first, then lowest priority,
  // then highest srrip, ties to the lowest index.
  logic                     hit, found_inv, vic_dirty;
  logic [WAY_BITS-1:0]      hit_way, inv_way, best_way, vic_way;
  logic [PRIORITY_BITS-1:0] best_prio;
  logic [SRRIP_BITS-1:0]    best_srrip;

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    found_inv  = 1'b0;
    inv_way    = '0;
    best_way   = '0;
    best_prio  = prio_q[set_idx][0];
    best_srrip = srrip_q[set_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = w[WAY_BITS-1:0];
      end
      if (!found_inv && !valid_q[set_idx][w]) begin
        found_inv = 1'b1;
        inv_way   = w[WAY_BITS-1:0];
      end
    end
    for (int w = 1; w < WAYS; w++) begin
      if (prio_q[set_idx][w] < best_prio ||
          (prio_q[set_idx][w] == best_prio && srrip_q[set_idx][w] > best_srrip)) begin
        best_way   = w[WAY_BITS-1:0];
        best_prio  = prio_q[set_idx][w];
        best_srrip = srrip_q[set_idx][w];
      end
    end
    vic_way   = found_inv ? inv_way : best_way;
    vic_dirty = valid_q[set_idx][vic_way] && dirty_q[set_idx][vic_way];
  end

  // A WRITE miss allocates only once any dirty victim has been written back,
  // so the victim contents stay intact while the WB channel is stalled.
  logic                  install_en;
  logic [WAY_BITS-1:0]   install_way;
  logic [DATA_WIDTH-1:0] install_data;

  assign install_en = (state_q == LOOKUP && !hit && is_write && !vic_dirty) ||
                      (state_q == WB && bus.i_dram_wr_ready && is_write) ||
                      (state_q == FILL_DATA && bus.i_dram_rd_data_valid && !is_consume);
  assign install_way  = (state_q == LOOKUP) ? vic_way : vic_q;
  assign install_data = is_write ? wdata_q : bus.i_dram_rd_data;

  always_ff @(posedge i_clk) begin
    if (!i_nreset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d                  = state_q;
    bus.o_req_ready          = 1'b0;
    bus.o_resp_valid         = 1'b0;
    bus.o_resp_data          = '0;
    bus.o_resp_hit           = 1'b0;
    bus.o_resp_err           = 1'b0;
    bus.o_dram_rd_valid      = 1'b0;
    bus.o_dram_rd_addr       = '0;
    bus.o_dram_rd_data_ready = 1'b0;
    bus.o_dram_wr_valid      = 1'b0;
    bus.o_dram_wr_addr       = '0;
    bus.o_dram_wr_data       = '0;
    case (state_q)
      IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) state_d = $onehot(bus.i_req_type) ? LOOKUP : RESP;
      end
      LOOKUP: begin
        if (hit)             state_d = RESP;
        else if (is_consume) state_d = FILL_REQ;
        else if (vic_dirty)  state_d = WB;
        else if (is_write)   state_d = RESP;
        else                 state_d = FILL_REQ;
      end
      WB: begin
        bus.o_dram_wr_valid = 1'b1;
        bus.o_dram_wr_addr  = {tag_q[set_idx][vic_q], set_idx, {OFFSET_BITS{1'b0}}};
        bus.o_dram_wr_data  = data_q[set_idx][vic_q];
        if (bus.i_dram_wr_ready) state_d = is_write ? RESP : FILL_REQ;
      end
      FILL_REQ: begin
        bus.o_dram_rd_valid = 1'b1;
        bus.o_dram_rd_addr  = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (bus.i_dram_rd_ready) state_d = FILL_DATA;
      end
      FILL_DATA: begin
        bus.o_dram_rd_data_ready = 1'b1;
        if (bus.i_dram_rd_data_valid) state_d = RESP;
      end
      RESP: begin
        bus.o_resp_valid = 1'b1;
        bus.o_resp_data  = resp_data_q;
        bus.o_resp_hit   = resp_hit_q;
        bus.o_resp_err   = resp_err_q;
        if (bus.i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      type_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vic_q       <= '0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          srrip_q[s][w] <= '0;
          prio_q[s][w]  <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: if (bus.i_req_valid) begin
          type_q      <= bus.i_req_type;
          addr_q      <= bus.i_req_addr;
          wdata_q     <= bus.i_req_data;
          resp_data_q <= '0;
          resp_hit_q  <= 1'b0;
          resp_err_q  <= !$onehot(bus.i_req_type);
        end
        LOOKUP: begin
          vic_q <= vic_way;
          if (hit) begin
            resp_hit_q <= 1'b1;
            srrip_q[set_idx][hit_way] <= '0;
            if (is_fetch && prio_q[set_idx][hit_way] != '1)
              prio_q[set_idx][hit_way] <= prio_q[set_idx][hit_way] + PRIORITY_BITS'(1);
            if (is_write) begin
              data_q[set_idx][hit_way]  <= wdata_q;
              dirty_q[set_idx][hit_way] <= 1'b1;
            end
            if (is_read || is_consume) resp_data_q <= data_q[set_idx][hit_way];
            // Consumed lines are dropped without writeback even when dirty.
            if (is_consume) begin
              valid_q[set_idx][hit_way] <= 1'b0;
              dirty_q[set_idx][hit_way] <= 1'b0;
              prio_q[set_idx][hit_way]  <= '0;
            end
          end
        end
        WB: if (bus.i_dram_wr_ready) dirty_q[set_idx][vic_q] <= 1'b0;
        FILL_DATA: if (bus.i_dram_rd_data_valid && (is_read || is_consume))
          resp_data_q <= bus.i_dram_rd_data;
        default: ;
      endcase
      // Placed after the case so a WRITE install overrides the WB dirty clear.
      if (install_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (w[WAY_BITS-1:0] == install_way) begin
            tag_q[set_idx][w]   <= tag;
            data_q[set_idx][w]  <= install_data;
            valid_q[set_idx][w] <= 1'b1;
            dirty_q[set_idx][w] <= is_write;
            srrip_q[set_idx][w] <= SRRIP_INS;
            prio_q[set_idx][w]  <= is_fetch ? PRIORITY_BITS'(1) : '0;
          end else if (valid_q[set_idx][w] && srrip_q[set_idx][w] != '1) begin
            srrip_q[set_idx][w] <= srrip_q[set_idx][w] + SRRIP_BITS'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fiber_cache_bank.sv
// tb/tb_fiber_cache_bank.sv - directed self-checking bench for fiber_cache_bank
module tb_fiber_cache_bank;
  localparam logic [3:0] T_FETCH = 4'b0001, T_READ = 4'b0010, T_WRITE = 4'b0100, T_CONSUME = 4'b1000;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  fiber_cache_bank_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();
  fiber_cache_bank dut (.i_clk(clk), .i_nreset(nreset), .bus(bus));

  int n_checks = 0;
  int n_err = 0;
  logic        saw_wr, saw_rd, rd_after_wr, got_resp;
  logic [31:0] rd_addr_seen, wr_addr_seen;
  logic [63:0] wr_data_seen, resp_data;
  logic        resp_hit, resp_err;
  int          lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [63:0] d);
    int cyc;
    saw_wr = 0; saw_rd = 0; rd_after_wr = 0; got_resp = 0;
    bus.i_req_type = t; bus.i_req_addr = a; bus.i_req_data = d; bus.i_req_valid = 1'b1;
    cyc = 0;
    while (!bus.o_req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!bus.o_req_ready) check("req_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int cyc;
    cyc = 1;
    while (cyc < 60 && !got_resp) begin
      if (bus.o_dram_wr_valid) begin
        saw_wr = 1; wr_addr_seen = bus.o_dram_wr_addr; wr_data_seen = bus.o_dram_wr_data;
      end
      if (bus.o_dram_rd_valid) begin
        if (!saw_rd) rd_after_wr = saw_wr;
        saw_rd = 1; rd_addr_seen = bus.o_dram_rd_addr;
      end
      if (bus.o_resp_valid && bus.i_resp_ready) begin
        got_resp = 1; lat = cyc;
        resp_data = bus.o_resp_data; resp_hit = bus.o_resp_hit; resp_err = bus.o_resp_err;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    if (!got_resp) check("resp_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic transact(input logic [3:0] t, input logic [31:0] a, input logic [63:0] d,
                          input logic [63:0] fill);
    bus.i_dram_rd_data = fill;
    issue(t, a, d);
    wait_resp();
  endtask

  initial begin
    int cyc;
    bus.i_req_type = '0; bus.i_req_addr = '0; bus.i_req_data = '0; bus.i_req_valid = 1'b0;
    bus.i_resp_ready = 1'b1; bus.i_dram_rd_ready = 1'b1; bus.i_dram_rd_data = '0;
    bus.i_dram_rd_data_valid = 1'b1; bus.i_dram_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.o_req_ready, 1);
    check("rst_resp_valid", bus.o_resp_valid, 0);
    check("rst_rd_valid", bus.o_dram_rd_valid, 0);
    check("rst_wr_valid", bus.o_dram_wr_valid, 0);
    check("rst_rd_data_ready", bus.o_dram_rd_data_ready, 0);
    check("rst_resp_data", bus.o_resp_data, 0);
    nreset = 1'b1;
    @(negedge clk);

    // Miss then hit on the same line.
    transact(T_READ, 32'h40, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    check("miss_rd_addr", rd_addr_seen, 32'h40);
    check("miss_data", resp_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check("miss_hit", resp_hit, 0);
    transact(T_READ, 32'h40, 0, 64'h0);
    check("hit_hit", resp_hit, 1);
    check("hit_latency", lat, 2);
    check("hit_data", resp_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check("hit_no_dram", saw_rd, 0);

    // Set 1: four fills, FETCH the first three twice, then a fifth tag.
    for (int i = 0; i < 4; i++) transact(T_READ, 32'h08 + 32'h80 * i, 0, 64'h100 + i);
    for (int i = 0; i < 3; i++) begin
      transact(T_FETCH, 32'h08 + 32'h80 * i, 0, 0);
      transact(T_FETCH, 32'h08 + 32'h80 * i, 0, 0);
    end
    check("fetch_hit", resp_hit, 1);
    check("fetch_data_zero", resp_data, 0);
    transact(T_READ, 32'h208, 0, 64'h205);
    check("e_miss", resp_hit, 0);
    check("e_no_wb", saw_wr, 0);
    check("srrip_w0", dut.srrip_q[1][0], 1);
    check("srrip_w1", dut.srrip_q[1][1], 1);
    check("srrip_w2", dut.srrip_q[1][2], 1);
    check("srrip_w3", dut.srrip_q[1][3], 2);
    check("prio_w0", dut.prio_q[1][0], 2);
    check("prio_w3", dut.prio_q[1][3], 0);
    transact(T_READ, 32'h08, 0, 0);
    check("a_still_hit", resp_hit, 1);
    transact(T_READ, 32'h188, 0, 64'h188);
    check("d_evicted", resp_hit, 0);

    // Dirty writeback in set 0 with a stalled write channel.
    transact(T_WRITE, 32'h80, 64'h1234, 0);
    check("wr_miss_hit", resp_hit, 0);
    check("wr_miss_no_fill", saw_rd, 0);
    for (int i = 2; i < 5; i++) transact(T_READ, 32'h80 * i, 0, 64'h500 + i);
    bus.i_dram_wr_ready = 1'b0;
    bus.i_dram_rd_data = 64'h280;
    issue(T_READ, 32'h280, 0);
    cyc = 0;
    while (!bus.o_dram_wr_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("wb_seen", bus.o_dram_wr_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("wb_hold_addr", bus.o_dram_wr_addr, 32'h80);
      check("wb_hold_data", bus.o_dram_wr_data, 64'h1234);
      check("wb_hold_no_rd", bus.o_dram_rd_valid, 0);
      @(negedge clk);
    end
    bus.i_dram_wr_ready = 1'b1;
    wait_resp();
    check("wb_then_rd", rd_after_wr, 1);
    check("wb_rd_addr", rd_addr_seen, 32'h280);
    check("wb_resp_data", resp_data, 64'h280);

    // CONSUME dirty hit and CONSUME miss.
    transact(T_WRITE, 32'h10, 64'h55, 0);
    transact(T_CONSUME, 32'h10, 0, 0);
    check("consume_hit", resp_hit, 1);
    check("consume_data", resp_data, 64'h55);
    check("consume_no_wb", saw_wr, 0);
    transact(T_READ, 32'h10, 0, 64'h77);
    check("after_consume_miss", resp_hit, 0);
    check("after_consume_rd", rd_addr_seen, 32'h10);
    transact(T_CONSUME, 32'h18, 0, 64'hBEEF);
    check("consume_miss_hit", resp_hit, 0);
    check("consume_miss_data", resp_data, 64'hBEEF);
    transact(T_READ, 32'h18, 0, 64'h99);
    check("consume_no_alloc", resp_hit, 0);

    // Illegal type with a stalled response.
    bus.i_resp_ready = 1'b0;
    issue(4'b0011, 32'h40, 0);
    cyc = 0;
    while (!bus.o_resp_valid && cyc < 10) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_resp_hold", bus.o_resp_valid, 1);
      check("err_req_ready", bus.o_req_ready, 0);
      check("err_no_rd", bus.o_dram_rd_valid, 0);
    end
    bus.i_resp_ready = 1'b1;
    wait_resp();
    check("err_flag", resp_err, 1);
    check("err_hit", resp_hit, 0);
    transact(T_READ, 32'h40, 0, 0);
    check("err_no_change", resp_hit, 1);

    // Reset in the middle of a fill.
    bus.i_dram_rd_data_valid = 1'b0;
    issue(T_READ, 32'h48, 0);
    cyc = 0;
    while (!bus.o_dram_rd_data_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("fill_wait", bus.o_dram_rd_data_ready, 1);
    nreset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", bus.o_req_ready, 1);
    check("abort_rd_valid", bus.o_dram_rd_valid, 0);
    check("abort_wr_valid", bus.o_dram_wr_valid, 0);
    check("abort_resp_valid", bus.o_resp_valid, 0);
    nreset = 1'b1;
    bus.i_dram_rd_data_valid = 1'b1;
    @(negedge clk);
    transact(T_READ, 32'h40, 0, 64'h4040);
    check("abort_old_miss", resp_hit, 0);
    check("abort_old_rd", saw_rd, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
